// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares one async SRAM port between the CPU and a debug/loader port,
// generating active-low strobes with WAIT_CYCLES wait states and a one-cycle ready pulse.
module mem_access_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] dbg_rdata,
  output logic        dbg_ready,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        Data_oe,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic grant_q, grant_d, last_q, last_d, we_q, we_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic ce_q, ce_d, oe_q, oe_d, wen_q, wen_d, doe_q, doe_d;
  logic cpu_rdy_q, cpu_rdy_d, dbg_rdy_q, dbg_rdy_d, busy_q, busy_d;
  logic pick_dbg;
  // grant/last hold 1 for the debug port; outputs are registered from next-state values
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    grant_d = grant_q;
    last_d = last_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    pick_dbg = dbg_req && (!cpu_req || !last_q);
    case (state_q)
      IDLE: if (cpu_req || dbg_req) begin
        state_d = SETUP;
        grant_d = pick_dbg;
        last_d = pick_dbg;
        we_d = pick_dbg ? dbg_we : cpu_we;
        addr_d = pick_dbg ? dbg_addr : cpu_addr;
        wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d = 4'(WAIT_CYCLES - 1);
      end
      ACCESS: if (cnt_q == 4'd0) begin
        state_d = DONE;
        rdata_d = we_q ? rdata_q : Data_from_SRAM;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ce_d = state_d == IDLE;
    oe_d = !(state_d == ACCESS && !we_d);
    wen_d = !(state_d == ACCESS && we_d);
    doe_d = we_d && (state_d == ACCESS || state_d == DONE);
    cpu_rdy_d = state_d == DONE && !grant_d;
    dbg_rdy_d = state_d == DONE && grant_d;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ce_q <= 1'b1;
      oe_q <= 1'b1;
      wen_q <= 1'b1;
      doe_q <= 1'b0;
      cpu_rdy_q <= 1'b0;
      dbg_rdy_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      grant_q <= grant_d;
      last_q <= last_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ce_q <= ce_d;
      oe_q <= oe_d;
      wen_q <= wen_d;
      doe_q <= doe_d;
      cpu_rdy_q <= cpu_rdy_d;
      dbg_rdy_q <= dbg_rdy_d;
      busy_q <= busy_d;
    end
  end
  assign cpu_rdata = rdata_q;
  assign dbg_rdata = rdata_q;
  assign cpu_ready = cpu_rdy_q;
  assign dbg_ready = dbg_rdy_q;
  assign ADDR = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign Data_oe = doe_q;
  assign CE = ce_q;
  assign UB = ce_q;
  assign LB = ce_q;
  assign OE = oe_q;
  assign WE = wen_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: directed vectors with an SRAM model and a cycle-offset reference model.
module tb_mem_access_arbiter;
  localparam int W = 2;
  logic Clk = 1'b0;
  logic Reset;
  logic cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [15:0] cpu_rdata, dbg_rdata, ADDR, Data_to_SRAM, Data_from_SRAM;
  logic cpu_ready, dbg_ready, Data_oe, CE, UB, LB, OE, WE, busy;
  logic [15:0] mem [0:65535];
  logic pre_en;
  logic [15:0] pre_addr, pre_data;
  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  logic m_act, m_we, m_dbg, m_last_dbg;
  int m_k;
  logic [15:0] m_addr, m_wdata, m_rreg;
  logic pick;
  logic [31:0] cpu_bits, dbg_bits;

  mem_access_arbiter #(.WAIT_CYCLES(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Data_oe(Data_oe), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .busy(busy)
  );

  always #5 Clk = ~Clk;

  assign Data_from_SRAM = mem[ADDR];
  always @(posedge Clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!CE && !WE) mem[ADDR] <= Data_to_SRAM;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total = total + 1;
    if (a !== e) begin
      bad = bad + 1;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  // Reference: an access is a window of W+2 cycles after the grant edge, indexed by m_k = 1..W+2.
  assign pick = dbg_req && (!cpu_req || !m_last_dbg);
  always @(posedge Clk) begin
    if (!Reset) begin
      m_act <= 1'b0; m_k <= 0; m_last_dbg <= 1'b1; m_rreg <= '0;
      m_addr <= '0; m_wdata <= '0; m_we <= 1'b0; m_dbg <= 1'b0; chk_en <= 1'b1;
    end else if (m_act) begin
      if (m_k == W + 2) m_act <= 1'b0;
      else begin
        m_k <= m_k + 1;
        if (m_k == W + 1 && !m_we) m_rreg <= mem[m_addr];
      end
    end else if (cpu_req || dbg_req) begin
      m_act <= 1'b1; m_k <= 1; m_dbg <= pick; m_last_dbg <= pick;
      m_we <= pick ? dbg_we : cpu_we;
      m_addr <= pick ? dbg_addr : cpu_addr;
      m_wdata <= pick ? dbg_wdata : cpu_wdata;
    end
  end

  always @(negedge Clk) begin : cmp
    logic strobe_win, sel;
    if (chk_en) begin
      strobe_win = m_act && m_k >= 2 && m_k <= W + 1;
      sel = m_act && m_k >= 1;
      chk("addr", 32'(ADDR), 32'(m_addr));
      chk("wdata", 32'(Data_to_SRAM), 32'(m_wdata));
      chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rreg));
      chk("dbg_rdata", 32'(dbg_rdata), 32'(m_rreg));
      chk("ce", 32'(CE), 32'(!sel));
      chk("ub", 32'(UB), 32'(!sel));
      chk("lb", 32'(LB), 32'(!sel));
      chk("oe", 32'(OE), 32'(!(strobe_win && !m_we)));
      chk("we", 32'(WE), 32'(!(strobe_win && m_we)));
      chk("data_oe", 32'(Data_oe), 32'(m_act && m_we && m_k >= 2));
      chk("busy", 32'(busy), 32'(m_act));
      chk("cpu_ready", 32'(cpu_ready), 32'(m_act && m_k == W + 2 && !m_dbg));
      chk("dbg_ready", 32'(dbg_ready), 32'(m_act && m_k == W + 2 && m_dbg));
    end
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 16'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
    #1;
    preload(16'h3000, 16'h1234);
    preload(16'h0020, 16'hCAFE);
    chk("rst_ce", 32'(CE), 32'd1);
    chk("rst_oe", 32'(OE), 32'd1);
    chk("rst_we", 32'(WE), 32'd1);
    chk("rst_doe", 32'(Data_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(cpu_ready), 32'd0);
    Reset = 1'b1;
    step(); chk("rd_c1_addr", 32'(ADDR), 32'h3000); chk("rd_c1_oe", 32'(OE), 32'd1); chk("rd_c1_ce", 32'(CE), 32'd0);
    step(); chk("rd_c2_oe", 32'(OE), 32'd0);
    step(); chk("rd_c3_oe", 32'(OE), 32'd0); chk("rd_c3_rdy", 32'(cpu_ready), 32'd0);
    step(); chk("rd_c4_rdy", 32'(cpu_ready), 32'd1); chk("rd_c4_data", 32'(cpu_rdata), 32'h1234);
    cpu_req = 1'b0;
    step(); chk("rd_c5_busy", 32'(busy), 32'd0); chk("rd_c5_ce", 32'(CE), 32'd1);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0010; dbg_wdata = 16'hBEEF;
    step(); chk("wr_c1_we", 32'(WE), 32'd1); chk("wr_c1_doe", 32'(Data_oe), 32'd0);
    step(); chk("wr_c2_we", 32'(WE), 32'd0); chk("wr_c2_doe", 32'(Data_oe), 32'd1);
    chk("wr_c2_data", 32'(Data_to_SRAM), 32'hBEEF); chk("wr_c2_addr", 32'(ADDR), 32'h0010);
    step(); chk("wr_c3_we", 32'(WE), 32'd0);
    step(); chk("wr_c4_we", 32'(WE), 32'd1); chk("wr_c4_doe", 32'(Data_oe), 32'd1);
    chk("wr_c4_rdy", 32'(dbg_ready), 32'd1); chk("wr_c4_rreg", 32'(dbg_rdata), 32'h1234);
    dbg_req = 1'b0;
    step(); chk("wr_c5_doe", 32'(Data_oe), 32'd0); chk("wr_mem", 32'(mem[16'h0010]), 32'hBEEF);
    Reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0020;
    step(); chk("rst2_rreg", 32'(cpu_rdata), 32'h0);
    Reset = 1'b1;
    cpu_bits = '0; dbg_bits = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      cpu_bits[c] = cpu_ready;
      dbg_bits[c] = dbg_ready;
      if (c == 4) chk("ct_c4_data", 32'(cpu_rdata), 32'hBEEF);
      if (c == 9) chk("ct_c9_data", 32'(dbg_rdata), 32'hCAFE);
      if (c == 19) begin cpu_req = 1'b0; dbg_req = 1'b0; end
    end
    chk("ct_cpu_pulses", cpu_bits, 32'h0000_4010);
    chk("ct_dbg_pulses", dbg_bits, 32'h0008_0200);
    cpu_req = 1'b1; cpu_addr = 16'h3000;
    step();
    step(); cpu_req = 1'b0;
    step();
    step(); chk("drop_c4_rdy", 32'(cpu_ready), 32'd1); chk("drop_c4_data", 32'(cpu_rdata), 32'h1234);
    step(); chk("drop_c5_busy", 32'(busy), 32'd0);
    step(); chk("drop_c6_busy", 32'(busy), 32'd0); chk("drop_c6_rdy", 32'(cpu_ready), 32'd0);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0030; dbg_wdata = 16'h5555;
    step();
    step(); chk("mr_c2_we", 32'(WE), 32'd0);
    step(); Reset = 1'b0;
    step(); chk("mr_we", 32'(WE), 32'd1); chk("mr_doe", 32'(Data_oe), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0); chk("mr_rdy", 32'(dbg_ready), 32'd0); chk("mr_ce", 32'(CE), 32'd1);
    dbg_req = 1'b0; Reset = 1'b1;
    step(); chk("mr_c5_busy", 32'(busy), 32'd0); chk("mr_c5_rdy", 32'(dbg_ready), 32'd0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences every SRAM access for the LC-3 datapath and shares the single SRAM port between two requesters: the CPU (MAR/MDR path driven by the control unit) and a debug/loader port (switch-driven memory load and inspect).
- Drives the active-low SRAM strobes with a programmable number of wait states.
- Returns read data and a one-cycle ready pulse to the granted requester.

Parameters:
- WAIT_CYCLES, 2, cycles the OE or WE strobe is held low per access; legal values are 1 to 15.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  16  CPU address (MAR).
- cpu_wdata  in  16  CPU write data (MDR).
- cpu_rdata  out  16  read data; valid in the cpu_ready cycle.
- cpu_ready  out  1  one-cycle completion pulse for the CPU.
- dbg_req  in  1  debug request; held until dbg_ready.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  16  debug address.
- dbg_wdata  in  16  debug write data.
- dbg_rdata  out  16  read data; valid in the dbg_ready cycle.
- dbg_ready  out  1  one-cycle completion pulse for the debug port.
- ADDR  out  16  SRAM address.
- Data_to_SRAM  out  16  write data toward the SRAM tri-state buffer.
- Data_from_SRAM  in  16  SRAM read data.
- Data_oe  out  1  enable for the external tri-state driver of Data_to_SRAM.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SETUP, ACCESS, DONE.
- Reset (Reset=0 at an edge):
  - state goes to IDLE and the wait counter clears.
  - CE, UB, LB, OE and WE go to 1.
  - Data_oe, cpu_ready, dbg_ready and busy go to 0.
  - ADDR, Data_to_SRAM and the shared read register go to 0.
  - last_grant goes to DBG, so the CPU wins the first contention.
  - A reset mid-access aborts it: strobes are high after that edge and no ready pulse is produced.
- Arbitration happens in IDLE only:
  - If only one request is high, that requester is granted.
  - If both are high, the requester not equal to last_grant wins.
  - On grant, latch grant, we, addr (to ADDR) and wdata (to Data_to_SRAM), update last_grant, and go to SETUP.
  - A request that arrives while the block is busy waits; it is never dropped.
- SETUP (1 cycle):
  - CE=0, UB=0, LB=0; OE=1, WE=1.
  - Address is stable. Load the counter with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles):
  - CE, UB and LB stay low.
  - Read: OE=0. Write: WE=0 and Data_oe=1.
  - The counter decrements each cycle; leave ACCESS when it reads 0.
  - For a read, capture Data_from_SRAM into the read register on the final ACCESS edge.
- DONE (1 cycle):
  - OE=1 and WE=1; CE, UB and LB stay low.
  - For a write, Data_oe stays 1, giving data hold past the WE rising edge.
  - ADDR is unchanged.
  - The granted requester's ready is 1.
  - Next state is IDLE, where all strobes return to 1 and Data_oe returns to 0.
- Latency: with the request sampled in IDLE at cycle 0, ready is high in cycle WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+3 cycles.
- Read data:
  - cpu_rdata and dbg_rdata both present the shared read register.
  - The register holds its value until the next read capture.
  - Write accesses never modify it.
- Request removed mid-access: the access still completes and the ready pulse is still generated. Requester inputs are ignored outside IDLE.
- Ready pulses are never asserted simultaneously, and each lasts exactly 1 cycle.
- All outputs are registered (no combinational path from the inputs).

Test Plan:
- Reset: hold Reset=0 for 2 cycles with cpu_req=1 -> CE=OE=WE=UB=LB=1, Data_oe=0, busy=0, no ready pulse; after release, the CPU is granted on the first edge.
- CPU read, WAIT_CYCLES=2: cpu_req=1, cpu_we=0, cpu_addr=16'h3000, SRAM returns 16'h1234 -> ADDR=16'h3000 from cycle 1; OE=0 in cycles 2-3; cpu_ready=1 only in cycle 4 with cpu_rdata=16'h1234.
- Debug write: dbg_we=1, dbg_addr=16'h0010, dbg_wdata=16'hBEEF -> WE=0 for exactly 2 cycles; Data_oe=1 in cycles 2-4; Data_to_SRAM=16'hBEEF; read register unchanged; dbg_ready pulses in cycle 4.
- Contention: both requests held high from reset release -> grant order CPU, DBG, CPU, DBG; ready pulses every 5 cycles, alternating.
- Request dropped: cpu_req deasserted in cycle 2 of a read -> the access completes and cpu_ready still pulses in cycle 4; the block is idle afterwards.
- Mid-operation reset: Reset=0 in cycle 3 of a write -> WE=1 and Data_oe=0 after that edge; no ready pulse; state is IDLE.
